// File: rtl/rot_arbiter_seq_if.sv
// Request/response bundle for the shared rotate-left engine.
//   req0_* / req1_* : two requester ports (valid/ready, operand, rotate amount)
//   rsp_*           : result port (valid/ready, rotated data, owning requester id)
//   busy            : engine is working on or holding an operation
// Modports: master = client/consumer side, slave = engine side.
interface rot_arbiter_seq_if #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_data;
    logic [AMT_W-1:0] req0_amt;
    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_data;
    logic [AMT_W-1:0] req1_amt;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_id;
    logic             busy;

    modport master (
        output req0_valid, req0_data, req0_amt,
        output req1_valid, req1_data, req1_amt,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_data, rsp_id, busy
    );

    modport slave (
        input  req0_valid, req0_data, req0_amt,
        input  req1_valid, req1_data, req1_amt,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_data, rsp_id, busy
    );
endinterface

// File: rtl/rot_arbiter_seq.sv
// Shared multi-cycle rotate-left engine with a two-port round-robin front end.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : rot_arbiter_seq_if.slave - two request ports, one response port, busy
// An accepted operand is rotated left by (amt mod WIDTH), at most MAX_STEP
// positions per cycle, then presented on the response port tagged with the
// id of the requester that issued it.
module rot_arbiter_seq #(
    parameter int WIDTH    = 8,
    parameter int AMT_W    = 4,
    parameter int MAX_STEP = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    rot_arbiter_seq_if.slave       bus
);
    localparam int SH_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [SH_W-1:0]  MAX_STEP_C = SH_W'(MAX_STEP);
    localparam logic [AMT_W-1:0] AMT_MASK   = AMT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] work_q;
    logic [SH_W-1:0]  rem_q;
    logic             id_q;
    logic             last_q;
    logic [WIDTH-1:0] res_q;
    logic             rsp_id_q;

    logic             grant0, grant1, accept;
    logic [WIDTH-1:0] sel_data;
    logic [AMT_W-1:0] sel_amt;
    logic [SH_W-1:0]  sel_eff;
    logic [SH_W-1:0]  step;
    logic [SH_W-1:0]  rem_left;
    logic [WIDTH-1:0] rotated;

    function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] d,
                                              input logic [SH_W-1:0]  s);
        // For s == 0 the right shift is by WIDTH and contributes nothing.
        return (d << s) | (d >> (WIDTH - int'(s)));
    endfunction

    always_comb begin
        grant0   = 1'b0;
        grant1   = 1'b0;
        state_d  = state_q;
        sel_data = '0;
        sel_amt  = '0;

        if (state_q == IDLE) begin
            // Tie goes to the port that did not win last time.
            grant0 = bus.req0_valid && (!bus.req1_valid || last_q);
            grant1 = bus.req1_valid && (!bus.req0_valid || !last_q);
        end
        accept = grant0 || grant1;

        sel_data = grant1 ? bus.req1_data : bus.req0_data;
        sel_amt  = grant1 ? bus.req1_amt  : bus.req0_amt;
        // Masking keeps every amount bit in the expression; only the low
        // log2(WIDTH) bits survive, giving amt mod WIDTH.
        sel_eff  = SH_W'(sel_amt & AMT_MASK);

        step     = (rem_q < MAX_STEP_C) ? rem_q : MAX_STEP_C;
        rem_left = rem_q - step;
        rotated  = rotl(work_q, step);

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = (sel_eff != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                if (rem_left == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            work_q   <= '0;
            rem_q    <= '0;
            id_q     <= 1'b0;
            last_q   <= 1'b1;
            res_q    <= '0;
            rsp_id_q <= 1'b0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        work_q <= sel_data;
                        rem_q  <= sel_eff;
                        id_q   <= grant1;
                        last_q <= grant1;
                        if (sel_eff == '0) begin
                            res_q    <= sel_data;
                            rsp_id_q <= grant1;
                        end
                    end
                end
                SHIFT: begin
                    work_q <= rotated;
                    rem_q  <= rem_left;
                    // Result register is loaded only on entry to DONE so the
                    // previous result stays visible while a new op shifts.
                    if (rem_left == '0) begin
                        res_q    <= rotated;
                        rsp_id_q <= id_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.rsp_valid  = (state_q == DONE);
    assign bus.rsp_data   = res_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_rot_arbiter_seq.sv
// Directed self-checking bench for rot_arbiter_seq (WIDTH=8, AMT_W=4, MAX_STEP=4).
module tb_rot_arbiter_seq;
    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    rot_arbiter_seq_if #(.WIDTH(8), .AMT_W(4)) bus ();

    rot_arbiter_seq #(.WIDTH(8), .AMT_W(4), .MAX_STEP(4)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input bit id, input bit v, input logic [7:0] d, input logic [3:0] a);
        if (id) begin
            bus.req1_valid = v; bus.req1_data = d; bus.req1_amt = a;
        end else begin
            bus.req0_valid = v; bus.req0_data = d; bus.req0_amt = a;
        end
    endtask

    task automatic step_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Called just after a negedge with the engine idle; runs one full op.
    task automatic run_op(input string tag, input bit id, input logic [7:0] d,
                          input logic [3:0] a, input logic [7:0] exp, input int k);
        set_req(id, 1'b1, d, a);
        #1;
        check({tag, "_rdy"},   id ? bus.req1_ready : bus.req0_ready, 1);
        check({tag, "_nordy"}, id ? bus.req0_ready : bus.req1_ready, 0);
        step_cycle();
        set_req(id, 1'b0, 8'h00, 4'h0);
        for (int i = 0; i < k; i++) begin
            check({tag, "_lat"}, bus.rsp_valid, 0);
            step_cycle();
        end
        check({tag, "_vld"},  bus.rsp_valid, 1);
        check({tag, "_data"}, bus.rsp_data, exp);
        check({tag, "_id"},   bus.rsp_id, id);
        bus.rsp_ready = 1'b1;
        step_cycle();
        bus.rsp_ready = 1'b0;
        check({tag, "_drop"}, bus.rsp_valid, 0);
        check({tag, "_idle"}, bus.busy, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.rsp_ready = 1'b0;
        set_req(1'b0, 1'b0, 8'h00, 4'h0);
        set_req(1'b1, 1'b0, 8'h00, 4'h0);
        repeat (2) @(negedge clk);
        check("rst_vld",  bus.rsp_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_r0",   bus.req0_ready, 0);
        check("rst_r1",   bus.req1_ready, 0);
        check("rst_data", bus.rsp_data, 8'h00);
        check("rst_id",   bus.rsp_id, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("op81_3",  1'b0, 8'h81, 4'd3,  8'h0C, 1);
        run_op("opA5_7",  1'b1, 8'hA5, 4'd7,  8'hD2, 2);
        run_op("op01_13", 1'b0, 8'h01, 4'd13, 8'h20, 2);
        run_op("op81_4",  1'b1, 8'h81, 4'd4,  8'h18, 1);
        run_op("op81_15", 1'b0, 8'h81, 4'd15, 8'hC0, 2);
        run_op("op3C_8",  1'b0, 8'h3C, 4'd8,  8'h3C, 0);
        run_op("op3C_0",  1'b1, 8'h3C, 4'd0,  8'h3C, 0);

        // Continuous dual requests; last winner was requester 1.
        bus.rsp_ready = 1'b1;
        set_req(1'b0, 1'b1, 8'h11, 4'd1);
        set_req(1'b1, 1'b1, 8'h22, 4'd1);
        for (int n = 0; n < 4; n++) begin
            #1;
            check("rr_r0", bus.req0_ready, (n % 2 == 0) ? 1 : 0);
            check("rr_r1", bus.req1_ready, (n % 2 == 1) ? 1 : 0);
            step_cycle();
            check("rr_busy",  bus.busy, 1);
            check("rr_r1_bz", bus.req1_ready, 0);
            check("rr_r0_bz", bus.req0_ready, 0);
            step_cycle();
            check("rr_vld",  bus.rsp_valid, 1);
            check("rr_id",   bus.rsp_id, (n % 2 == 1) ? 1 : 0);
            check("rr_data", bus.rsp_data, (n % 2 == 1) ? 8'h44 : 8'h22);
            step_cycle();
        end
        set_req(1'b0, 1'b0, 8'h00, 4'h0);
        set_req(1'b1, 1'b0, 8'h00, 4'h0);
        bus.rsp_ready = 1'b0;

        // Backpressure: result must hold and no new accept while in DONE.
        set_req(1'b0, 1'b1, 8'h81, 4'd3);
        #1;
        check("bp_rdy", bus.req0_ready, 1);
        step_cycle();
        set_req(1'b0, 1'b0, 8'h00, 4'h0);
        step_cycle();
        set_req(1'b1, 1'b1, 8'h55, 4'd2);
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_vld",  bus.rsp_valid, 1);
            check("bp_data", bus.rsp_data, 8'h0C);
            check("bp_id",   bus.rsp_id, 0);
            check("bp_r1",   bus.req1_ready, 0);
            step_cycle();
        end
        bus.rsp_ready = 1'b1;
        step_cycle();
        set_req(1'b1, 1'b0, 8'h00, 4'h0);
        bus.rsp_ready = 1'b0;
        check("bp_done", bus.rsp_valid, 0);
        check("bp_hold", bus.rsp_data, 8'h0C);

        // Reset mid-SHIFT after a requester-0 win; tie must go back to 0.
        set_req(1'b0, 1'b1, 8'hA5, 4'd7);
        step_cycle();
        set_req(1'b0, 1'b0, 8'h00, 4'h0);
        check("mid_busy", bus.busy, 1);
        rst_n = 1'b0;
        #1;
        check("ar_vld",  bus.rsp_valid, 0);
        check("ar_busy", bus.busy, 0);
        check("ar_data", bus.rsp_data, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("ar_stay", bus.busy, 0);
        set_req(1'b0, 1'b1, 8'h01, 4'd1);
        set_req(1'b1, 1'b1, 8'h80, 4'd1);
        #1;
        check("ar_r0", bus.req0_ready, 1);
        check("ar_r1", bus.req1_ready, 0);
        step_cycle();
        set_req(1'b0, 1'b0, 8'h00, 4'h0);
        set_req(1'b1, 1'b0, 8'h00, 4'h0);
        step_cycle();
        check("ar_res_vld",  bus.rsp_valid, 1);
        check("ar_res_data", bus.rsp_data, 8'h02);
        check("ar_res_id",   bus.rsp_id, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rot_arbiter_seq.md
Name: rot_arbiter_seq

Overview:
Shared rotate-left engine for two requesters.
- Arbitrates round-robin between two request ports.
- Performs the rotate over one or more cycles, each cycle rotating by at most MAX_STEP bit positions.
- Returns the result on a valid/ready response port tagged with the requester id.
- Sits between client blocks and the single rotate datapath, so no client needs a private shifter.

Parameters:
WIDTH, 8, data width in bits; must be a power of two, >= 2.
AMT_W, 4, rotate-amount width; must be >= log2(WIDTH).
MAX_STEP, 4, maximum rotate per cycle; range 1..WIDTH-1.

Ports:
clk  input  1  single clock, rising edge.
rst_n  input  1  reset, asynchronous assert, active-low.
req0_valid  input  1  requester 0 has a request.
req0_ready  output  1  requester 0 request accepted this cycle.
req0_data  input  WIDTH  requester 0 operand.
req0_amt  input  AMT_W  requester 0 rotate-left amount.
req1_valid  input  1  requester 1 has a request.
req1_ready  output  1  requester 1 request accepted this cycle.
req1_data  input  WIDTH  requester 1 operand.
req1_amt  input  AMT_W  requester 1 rotate-left amount.
rsp_valid  output  1  result available.
rsp_ready  input  1  consumer takes the result.
rsp_data  output  WIDTH  rotated result.
rsp_id  output  1  id of the requester that owns rsp_data.
busy  output  1  engine is not in IDLE.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; rsp_valid = 0; rsp_data = 0; rsp_id = 0; busy = 0.
  - Round-robin pointer last = 1, so requester 0 wins the first tie.
  - Any in-flight operation is discarded; nothing is replayed after reset.
- Rotate definition: rotl(d, s) = {d[WIDTH-1-s:0], d[WIDTH-1:WIDTH-s]}; rotl(d, 0) = d.
- Effective amount: eff = amt mod WIDTH, taken from the low log2(WIDTH) bits of amt.
- States:
  - IDLE: busy = 0.
    - Grant logic is combinational: if only one valid is high, grant it. If both are high, grant the port that is not last.
    - reqX_ready = (state == IDLE) && grantX. Ready is never high outside IDLE and never high for both ports.
    - On the accept edge: capture data into the work register, set rem = eff, record id, and set last = granted id.
    - Next state is SHIFT if eff != 0, otherwise DONE.
  - SHIFT: each edge computes step = min(rem, MAX_STEP), then work <= rotl(work, step) and rem <= rem - step.
    - Go to DONE when rem - step == 0.
    - Number of SHIFT cycles k = ceil(eff / MAX_STEP).
  - DONE: rsp_valid = 1; rsp_data and rsp_id hold stable until rsp_ready.
    - On the edge where rsp_valid && rsp_ready, go to IDLE and drop rsp_valid.
- Latency: rsp_valid rises exactly k edges after the accept edge (k = 0 means the first edge after accept).
- Throughput: no new accept in DONE. At least one IDLE cycle separates successive operations.
- Requester rule: hold valid, data and amt stable until ready. Dropping valid without ready is legal and has no effect.
- rsp_ready is ignored outside DONE.
- rsp_data holds the last result after it is taken; rsp_valid is the only qualifier.
- Arbitration fairness: under continuous dual requests the grants strictly alternate.

Test Plan:
- Reset with all inputs 0 -> rsp_valid=0, busy=0, req0_ready=req1_ready=0. Release rst_n, then req0_valid=1 -> req0_ready=1 in the same cycle.
- req0: data=0x81, amt=3 (MAX_STEP=4) -> accepted; rsp_valid rises 1 edge later with rsp_data=0x0C, rsp_id=0.
- req1: data=0xA5, amt=7 -> 2 SHIFT cycles (4+3); rsp_data=0xD2, rsp_id=1. Also req0: data=0x01, amt=13 (eff 5) -> rsp_data=0x20 after 2 edges.
- amt=0 and amt=8 with data=0x3C -> rsp_data=0x3C, rsp_valid on the first edge after accept, no SHIFT cycles.
- Both requesters valid continuously, rsp_ready=1 -> grant order 0,1,0,1. req1_ready stays 0 while busy=1.
- Backpressure and reset:
  - rsp_ready held 0 for 5 cycles -> rsp_valid, rsp_data and rsp_id stable, no new accept.
  - Assert rst_n mid-SHIFT -> immediately rsp_valid=0, busy=0; after release the next accept is from req0.
